vid_sram_ctl: RTL
=================

Name: vid_sram_ctl

Overview:
- Single-port async SRAM controller (256K x 32) shared by the RISC CPU bus and the 1024x768 video fetch stage.
- Sits directly upstream of the display controller: services its one-cycle video read pulse with data valid in the same cycle.
- Sequences CPU reads and writes, and stalls the CPU whenever a video fetch or a multi-cycle write occupies the SRAM.

Parameters:
- AW, 18, SRAM word-address width.
- DW, 32, SRAM data width; byte lanes = DW/8.

Ports:
- clk  in  1  system clock, same clock as the video request pulse.
- rst  in  1  asynchronous active-low reset.
- cpu_adr  in  AW  CPU word address.
- cpu_rd  in  1  read request, held until cpu_stall=0.
- cpu_wr  in  1  write request, held until cpu_stall=0.
- cpu_ben  in  DW/8  write byte enables, active-high.
- cpu_wdata  in  DW  write data.
- cpu_rdata  out  DW  registered read data.
- cpu_stall  out  1  CPU must hold its request while high.
- vid_req  in  1  single-cycle video read pulse.
- vid_adr  in  AW  video word address.
- vid_data  out  DW  video read data, combinational from sram_dq.
- sram_adr  out  AW  SRAM address.
- sram_dq  inout  DW  SRAM data bus.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- sram_be_n  out  DW/8  byte lane enables.

Behaviour:
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Request cycle (IDLE, request seen): latch cpu_adr, cpu_ben, cpu_wdata and the rd/wr flag; cpu_stall=1.
  - If cpu_rd and cpu_wr are both high, the write wins.
- Read: IDLE -> RD.
  - In RD: sram_adr=latched address, oe_n=0, be_n=0, dq high-Z, cpu_stall=0.
  - cpu_rdata <= sram_dq at the end of RD; RD -> IDLE.
  - Data is valid from the cycle after RD and is held until the next completed read.
- Write: IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> IDLE.
  - Throughout: address, dq=latched data and be_n=~latched ben are driven; oe_n=1.
  - we_n=0 only in WR_PULSE.
  - cpu_stall=1 in WR_SETUP and WR_PULSE, 0 in WR_HOLD.
- Video cycle: vid_req has absolute priority in any state.
  - sram_adr=vid_adr, oe_n=0, we_n=1, be_n=0, ce_n=0, dq high-Z.
  - vid_data=sram_dq in that same cycle.
  - cpu_stall=1 that cycle. The FSM does not advance: RD stays RD.
  - WR_PULSE returns to WR_SETUP, so the full we pulse is reissued. WR_SETUP and WR_HOLD hold their state.
- Back-to-back vid_req (protocol violation; the video stage spaces pulses at least 32 pixels apart): each cycle is served, and the CPU is deferred indefinitely.
- sram_ce_n=0 when state!=IDLE or vid_req=1, else 1.
- In IDLE with no request: oe_n=1, we_n=1, dq high-Z, cpu_stall=0.
- CPU request dropped while the FSM is busy: the latched access completes anyway and no new access starts.
- Reset (rst=0, async, including mid-write):
  - State -> IDLE; we_n, oe_n, ce_n forced to 1 immediately; dq high-Z.
  - cpu_stall=0, cpu_rdata=0, be_n all 1.
  - vid_req is ignored while reset is asserted.
- Address arithmetic: none. Addresses pass through at width AW with no wrap logic.

Optional Feature:
- Macro: VID_SRAM_PERF_EN.
- Defined:
  - Adds outputs perf_vid[31:0] (count of served vid_req cycles) and perf_stall[31:0] (count of cycles with cpu_stall=1 while cpu_rd|cpu_wr).
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Read: cpu_rd at addr 0x00010, SRAM model holds 0xDEADBEEF -> stall 1 cycle; cpu_rdata=0xDEADBEEF from cycle 2; oe_n low only in RD.
- Write: cpu_wr addr 0x3FFFF, data 0x12345678, ben=4'b0101 -> we_n low exactly 1 cycle (cycle 2); be_n=4'b1010; stall low in cycle 3; read-back gives 0x??34??78 with the other bytes unchanged.
- Video priority: vid_req during WR_PULSE with vid_adr=0x37FC0 -> that cycle sram_adr=0x37FC0, we_n=1, vid_data=model word; write completes 2 cycles later than nominal with one full we pulse.
- Read collision: vid_req in the RD cycle -> cpu_rdata not updated that cycle; RD repeats; CPU gets the correct data one cycle late.
- Reset mid-write: drop rst in WR_PULSE -> we_n=1 without waiting for clk; after release the FSM is IDLE, stall=0, rdata=0, and the SRAM word is untouched or fully written, never a partial byte-lane mix beyond ben.
- With VID_SRAM_PERF_EN: 32 lines of 32 vid_req pulses plus 10 stalled writes -> perf_vid=1024, perf_stall = counted stall cycles (30 plus video collisions).

Source files
------------

// File: rtl/vid_sram_ctl_if.sv
// vid_sram_ctl_if: CPU bus and video fetch signals for the shared SRAM controller.
//   master : CPU/video side. Drives cpu_adr/rd/wr/ben/wdata, vid_req/vid_adr;
//            receives cpu_rdata, cpu_stall and vid_data.
//   slave  : controller side, opposite directions.
interface vid_sram_ctl_if #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 32
) ();
    logic [AW-1:0]   cpu_adr;
    logic            cpu_rd;
    logic            cpu_wr;
    logic [DW/8-1:0] cpu_ben;
    logic [DW-1:0]   cpu_wdata;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_stall;
    logic            vid_req;
    logic [AW-1:0]   vid_adr;
    logic [DW-1:0]   vid_data;

    modport master (
        output cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata, vid_req, vid_adr,
        input  cpu_rdata, cpu_stall, vid_data
    );

    modport slave (
        input  cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata, vid_req, vid_adr,
        output cpu_rdata, cpu_stall, vid_data
    );
endinterface

// File: rtl/vid_sram_ctl.sv
// vid_sram_ctl: single-port async SRAM controller shared by the CPU bus and the
// video fetch stage. A video pulse is served in the cycle it arrives (data is
// combinational from the SRAM bus); CPU reads take one SRAM cycle, CPU writes
// a setup/pulse/hold sequence. The CPU is stalled while the SRAM is occupied.
//
// Ports:
//   clk        system clock (also the video pulse clock)
//   rst        asynchronous active-low reset
//   bus        vid_sram_ctl_if.slave: cpu_* request/response, vid_* fetch
//   sram_adr   SRAM word address
//   sram_dq    SRAM bidirectional data bus
//   sram_ce_n, sram_oe_n, sram_we_n, sram_be_n   SRAM strobes (active low)
//   perf_vid, perf_stall   event counters, present only with VID_SRAM_PERF_EN
//
// Build option: define VID_SRAM_PERF_EN to add the performance counters.
module vid_sram_ctl #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    vid_sram_ctl_if.slave   bus,
    output logic [AW-1:0]   sram_adr,
    inout  wire  [DW-1:0]   sram_dq,
    output logic            sram_ce_n,
    output logic            sram_oe_n,
    output logic            sram_we_n,
    output logic [DW/8-1:0] sram_be_n
`ifdef VID_SRAM_PERF_EN
    ,
    output logic [31:0]     perf_vid,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned BW = DW / 8;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   adr_q;
    logic [BW-1:0]   ben_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;

    logic            vid_act;
    logic            cpu_req;
    logic            latch_en;
    logic            rd_done;
    logic            dq_oe;
    logic            stall;

    // Qualify with reset so nothing reaches the SRAM pins while rst is low.
    assign vid_act = bus.vid_req & rst;
    assign cpu_req = (bus.cpu_rd | bus.cpu_wr) & rst;

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        rd_done   = 1'b0;
        dq_oe     = 1'b0;
        stall     = 1'b0;
        sram_adr  = adr_q;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_be_n = '1;

        if (vid_act) begin
            // Video steals the SRAM for this cycle; CPU sequence is frozen,
            // except an interrupted write pulse is restarted from setup.
            sram_adr  = bus.vid_adr;
            sram_oe_n = 1'b0;
            sram_be_n = '0;
            stall     = 1'b1;
            if (state_q == StWrPulse) begin
                state_d = StWrSetup;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        latch_en = 1'b1;
                        stall    = 1'b1;
                        // The rd/wr choice is carried by the next state; write wins.
                        state_d  = bus.cpu_wr ? StWrSetup : StRd;
                    end
                end
                StRd: begin
                    sram_oe_n = 1'b0;
                    sram_be_n = '0;
                    rd_done   = 1'b1;
                    state_d   = StIdle;
                end
                StWrSetup: begin
                    sram_be_n = ~ben_q;
                    dq_oe     = 1'b1;
                    stall     = 1'b1;
                    state_d   = StWrPulse;
                end
                StWrPulse: begin
                    sram_be_n = ~ben_q;
                    sram_we_n = 1'b0;
                    dq_oe     = 1'b1;
                    stall     = 1'b1;
                    state_d   = StWrHold;
                end
                StWrHold: begin
                    sram_be_n = ~ben_q;
                    dq_oe     = 1'b1;
                    state_d   = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign sram_ce_n     = ~((state_q != StIdle) | vid_act);
    assign sram_dq       = dq_oe ? wdata_q : {DW{1'bz}};
    assign bus.cpu_stall = stall;
    assign bus.cpu_rdata = rdata_q;
    assign bus.vid_data  = sram_dq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            adr_q   <= '0;
            ben_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                adr_q   <= bus.cpu_adr;
                ben_q   <= bus.cpu_ben;
                wdata_q <= bus.cpu_wdata;
            end
            if (rd_done) begin
                rdata_q <= sram_dq;
            end
        end
    end

`ifdef VID_SRAM_PERF_EN
    logic [31:0] perf_vid_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_vid_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (vid_act) begin
                perf_vid_q <= perf_vid_q + 32'd1;
            end
            if (stall && (bus.cpu_rd || bus.cpu_wr)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_vid   = perf_vid_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
